// File: rtl/pipe_pkg.sv
// Shared constants and helpers for the pipeline register chain.
package pipe_pkg;

  // Encoding of an all-zero MIPS instruction (sll $0,$0,0), used as the bubble.
  localparam logic [31:0] MIPS_NOP = 32'h0000_0000;

  // Deepest chain supported by the occupancy logic and the elaboration check.
  localparam int PIPE_MAX_DEPTH = 8;

  // What a stage does on the coming edge once reset is known to be low.
  typedef enum logic [1:0] {
    STAGE_HOLD  = 2'd0,
    STAGE_LOAD  = 2'd1,
    STAGE_FLUSH = 2'd2
  } stage_op_e;

  // Bits needed to count 0..depth valid stages.
  function automatic int occ_width(input int depth);
    return $clog2(depth + 1);
  endfunction

  // Flush squashes even a stalled stage; otherwise en selects load or hold.
  function automatic stage_op_e stage_op(input logic flush, input logic en);
    if (flush) begin
      return STAGE_FLUSH;
    end
    if (en) begin
      return STAGE_LOAD;
    end
    return STAGE_HOLD;
  endfunction

endpackage

// File: rtl/pipe_stage.sv
// One pipeline stage: a data register plus its valid bit, with
// reset > flush > enable priority.
module pipe_stage
  import pipe_pkg::*;
#(
  parameter int               WIDTH     = 32,
  parameter logic [WIDTH-1:0] RESET_VAL = '0,
  parameter logic [WIDTH-1:0] FLUSH_VAL = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             flush,
  input  logic [WIDTH-1:0] d,
  input  logic             d_valid,
  output logic [WIDTH-1:0] q,
  output logic             q_valid
);

  logic [WIDTH-1:0] data_d;
  logic [WIDTH-1:0] data_q;
  logic             vld_d;
  logic             vld_q;
  stage_op_e        op;

  // Next-state selection for flush / load / hold.
  always_comb begin
    op     = stage_op(flush, en);
    data_d = data_q;
    vld_d  = vld_q;
    unique case (op)
      STAGE_FLUSH: begin
        data_d = FLUSH_VAL;
        vld_d  = 1'b0;
      end
      STAGE_LOAD: begin
        data_d = d;
        vld_d  = d_valid;
      end
      default: begin
        data_d = data_q;
        vld_d  = vld_q;
      end
    endcase
  end

  // Stage state; reset overrides whatever flush or en request.
  always_ff @(posedge clk) begin
    if (reset) begin
      data_q <= RESET_VAL;
      vld_q  <= 1'b0;
    end else begin
      data_q <= data_d;
      vld_q  <= vld_d;
    end
  end

  assign q       = data_q;
  assign q_valid = vld_q;

endmodule

// File: rtl/pipe_reg_chain.sv
// DEPTH-stage pipeline register chain with stall, flush and a live
// count of stages holding valid data.
module pipe_reg_chain
  import pipe_pkg::*;
#(
  parameter int               WIDTH     = 32,
  parameter int               DEPTH     = 1,
  parameter logic [WIDTH-1:0] RESET_VAL = '0,
  parameter logic [WIDTH-1:0] FLUSH_VAL = '0
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         en,
  input  logic                         flush,
  input  logic [WIDTH-1:0]             d,
  input  logic                         d_valid,
  output logic [WIDTH-1:0]             q,
  output logic                         q_valid,
  output logic [occ_width(DEPTH)-1:0]  occupancy
);

  localparam int OCC_W = occ_width(DEPTH);

  if ((DEPTH < 1) || (DEPTH > PIPE_MAX_DEPTH)) begin : g_depth_check
    $error("pipe_reg_chain: DEPTH must be within 1..8");
  end

  logic [WIDTH-1:0] stage_data [DEPTH];
  logic             stage_vld  [DEPTH];

  for (genvar i = 0; i < DEPTH; i++) begin : g_stage
    logic [WIDTH-1:0] in_data;
    logic             in_vld;

    // Stage 0 takes the chain input; later stages take their predecessor.
    if (i == 0) begin : g_head
      assign in_data = d;
      assign in_vld  = d_valid;
    end else begin : g_body
      assign in_data = stage_data[i-1];
      assign in_vld  = stage_vld[i-1];
    end

    pipe_stage #(
      .WIDTH     (WIDTH),
      .RESET_VAL (RESET_VAL),
      .FLUSH_VAL (FLUSH_VAL)
    ) u_stage (
      .clk     (clk),
      .reset   (reset),
      .en      (en),
      .flush   (flush),
      .d       (in_data),
      .d_valid (in_vld),
      .q       (stage_data[i]),
      .q_valid (stage_vld[i])
    );
  end

  assign q       = stage_data[DEPTH-1];
  assign q_valid = stage_vld[DEPTH-1];

  logic [OCC_W-1:0] occ_d;
  logic [OCC_W-1:0] occ_q;

  // One word enters and one leaves per advance, so the count moves by
  // d_valid minus the outgoing last-stage valid; it stays in 0..DEPTH.
  always_comb begin
    occ_d = occ_q;
    if (flush) begin
      occ_d = '0;
    end else if (en) begin
      occ_d = occ_q + OCC_W'(d_valid) - OCC_W'(q_valid);
    end
  end

  // Occupancy register, cleared by reset like the stages.
  always_ff @(posedge clk) begin
    if (reset) begin
      occ_q <= '0;
    end else begin
      occ_q <= occ_d;
    end
  end

  assign occupancy = occ_q;

endmodule

// File: tb/tb_pipe_reg_chain.sv
// Scoreboard bench for pipe_reg_chain: DEPTH=3 chains (zero and all-ones
// reset values) and a DEPTH=1 byte-wide chain.
module tb_pipe_reg_chain;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // DUT A: WIDTH 32, DEPTH 3, RESET_VAL 0, FLUSH_VAL 0
  logic        rst = 1'b1, en = 1'b0, flush = 1'b0, dv = 1'b0;
  logic [31:0] d = 32'h0;
  logic [31:0] q;
  logic        qv;
  logic [1:0]  occ;

  // DUT B: same stream as A, own reset/flush, RESET_VAL all ones
  logic        rst_b = 1'b1, flush_b = 1'b0;
  logic [31:0] qb;
  logic        qvb;
  logic [1:0]  occb;

  // DUT C: WIDTH 8, DEPTH 1
  logic        c_rst = 1'b1, c_en = 1'b0, c_flush = 1'b0, c_dv = 1'b0;
  logic [7:0]  c_d = 8'h0;
  logic [7:0]  c_q;
  logic        c_qv;
  logic [0:0]  c_occ;

  pipe_reg_chain #(.WIDTH(32), .DEPTH(3), .RESET_VAL(32'h0), .FLUSH_VAL(32'h0)) u_dut_a (
    .clk(clk), .reset(rst), .en(en), .flush(flush), .d(d), .d_valid(dv),
    .q(q), .q_valid(qv), .occupancy(occ));

  pipe_reg_chain #(.WIDTH(32), .DEPTH(3), .RESET_VAL(32'hFFFF_FFFF), .FLUSH_VAL(32'h0)) u_dut_b (
    .clk(clk), .reset(rst_b), .en(en), .flush(flush_b), .d(d), .d_valid(dv),
    .q(qb), .q_valid(qvb), .occupancy(occb));

  pipe_reg_chain #(.WIDTH(8), .DEPTH(1), .RESET_VAL(8'h0), .FLUSH_VAL(8'h0)) u_dut_c (
    .clk(clk), .reset(c_rst), .en(c_en), .flush(c_flush), .d(c_d), .d_valid(c_dv),
    .q(c_q), .q_valid(c_qv), .occupancy(c_occ));

  typedef enum logic [1:0] {K_CLR, K_ADV, K_STALL} kind_e;

  int          n_chk  = 0;
  int          n_fail = 0;
  logic        chk    = 1'b0;
  kind_e       kind   = K_CLR;
  logic [2:0]  mv     = 3'b000;   // expected valid bits of A, [2] = last stage
  logic [31:0] sb [$];            // valid words expected to leave A, in order
  logic [31:0] prev_q = 32'h0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  // Drive A for one edge and advance the expected-state model.
  task automatic cyc(input logic r, input logic f, input logic e, input logic v,
                     input logic [31:0] dd);
    rst = r; flush = f; en = e; dv = v; d = dd;
    @(posedge clk);
    #1;
    if (r || f) begin
      mv = 3'b000;
      sb.delete();
      kind = K_CLR;
    end else if (e) begin
      mv = {mv[1:0], v};
      if (v) sb.push_back(dd);
      kind = K_ADV;
    end else begin
      kind = K_STALL;
    end
  endtask

  // Monitor: compare A against the model on every falling edge.
  always @(negedge clk) begin
    if (chk) begin
      check("a_q_valid", 32'(qv), 32'(mv[2]));
      check("a_occupancy", 32'(occ), 32'($countones(mv)));
      if (kind == K_STALL) check("a_stall_hold", q, prev_q);
      if (kind == K_ADV && qv) begin
        if (sb.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL a_data: got %h with no word expected", q);
        end else begin
          check("a_data", q, sb.pop_front());
        end
      end
      prev_q = q;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // reset held two cycles
    cyc(1, 0, 0, 0, 32'h0);
    chk = 1'b1;
    cyc(1, 0, 0, 0, 32'h0);
    check("a_rst_q", q, 32'h0);
    check("b_rst_q", qb, 32'hFFFF_FFFF);
    check("b_rst_occ", 32'(occb), 32'h0);
    check("c_rst_q", 32'(c_q), 32'h0);
    check("c_rst_qv", 32'(c_qv), 32'h0);
    rst_b = 1'b0;
    c_rst = 1'b0;

    // plain stream: first word on q after the 3rd edge
    cyc(0, 0, 1, 1, 32'h1111_0001);
    cyc(0, 0, 1, 1, 32'h1111_0002);
    cyc(0, 0, 1, 1, 32'h1111_0003);
    check("a_lat3_q", q, 32'h1111_0001);
    check("a_lat3_occ", 32'(occ), 32'd3);
    for (int i = 0; i < 3; i++) cyc(0, 0, 1, 0, 32'h0);

    // same stream with a two-cycle stall after the second word
    cyc(0, 0, 1, 1, 32'h1111_0001);
    cyc(0, 0, 1, 1, 32'h1111_0002);
    cyc(0, 0, 0, 1, 32'hCAFE_0000);
    cyc(0, 0, 0, 1, 32'hCAFE_0001);
    check("a_stall_qv", 32'(qv), 32'h0);
    cyc(0, 0, 1, 1, 32'h1111_0003);
    check("a_stall_lat_q", q, 32'h1111_0001);
    check("a_stall_lat_qv", 32'(qv), 32'h1);
    for (int i = 0; i < 3; i++) cyc(0, 0, 1, 0, 32'h0);

    // fill, then flush while stalled; DEADBEEF must never emerge
    cyc(0, 0, 1, 1, 32'h2222_0001);
    cyc(0, 0, 1, 1, 32'h2222_0002);
    cyc(0, 0, 1, 1, 32'h2222_0003);
    check("a_full_occ", 32'(occ), 32'd3);
    cyc(0, 1, 0, 1, 32'hDEAD_BEEF);
    check("a_flush_q", q, 32'h0);
    check("a_flush_occ", 32'(occ), 32'h0);
    for (int i = 0; i < 3; i++) cyc(0, 0, 1, 0, 32'h0);

    // reset and flush together: reset value wins on B; A reset mid-stream
    cyc(0, 0, 1, 1, 32'h3333_0001);
    cyc(0, 0, 1, 1, 32'h3333_0002);
    cyc(0, 0, 1, 1, 32'h3333_0003);
    check("b_full_occ", 32'(occb), 32'd3);
    rst_b = 1'b1;
    flush_b = 1'b1;
    cyc(1, 1, 1, 1, 32'h4444_0000);
    check("b_rstflush_q", qb, 32'hFFFF_FFFF);
    check("b_rstflush_qv", 32'(qvb), 32'h0);
    check("b_rstflush_occ", 32'(occb), 32'h0);
    check("a_midrst_q", q, 32'h0);
    rst_b = 1'b0;
    flush_b = 1'b0;

    // alternating valid
    cyc(0, 0, 1, 1, 32'h5555_0001);
    cyc(0, 0, 1, 0, 32'h5555_0002);
    cyc(0, 0, 1, 1, 32'h5555_0003);
    check("a_alt_occ", 32'(occ), 32'd2);
    cyc(0, 0, 1, 0, 32'h5555_0004);
    check("a_alt_q", q, 32'h5555_0002);
    check("a_alt_qv", 32'(qv), 32'h0);
    cyc(0, 0, 1, 1, 32'h5555_0005);
    cyc(0, 0, 1, 0, 32'h5555_0006);
    for (int i = 0; i < 3; i++) cyc(0, 0, 1, 0, 32'h0);

    // DEPTH=1 chain, A stalled meanwhile
    c_d = 8'hA5; c_dv = 1'b1; c_en = 1'b1;
    cyc(0, 0, 0, 0, 32'h0);
    check("c_q", 32'(c_q), 32'h0000_00A5);
    check("c_qv", 32'(c_qv), 32'h1);
    check("c_occ", 32'(c_occ), 32'h1);
    c_d = 8'h5A; c_dv = 1'b0;
    cyc(0, 0, 0, 0, 32'h0);
    check("c_inv_q", 32'(c_q), 32'h0000_005A);
    check("c_inv_qv", 32'(c_qv), 32'h0);
    check("c_inv_occ", 32'(c_occ), 32'h0);
    c_d = 8'h3C; c_dv = 1'b1;
    cyc(0, 0, 0, 0, 32'h0);
    c_flush = 1'b1; c_en = 1'b0;
    cyc(0, 0, 0, 0, 32'h0);
    check("c_flush_q", 32'(c_q), 32'h0);
    check("c_flush_qv", 32'(c_qv), 32'h0);
    check("c_flush_occ", 32'(c_occ), 32'h0);
    c_flush = 1'b0;

    cyc(0, 0, 0, 0, 32'h0);
    check("a_sb_empty", 32'(sb.size()), 32'h0);
    @(negedge clk);
    chk = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
